// File: rtl/des_permutation_pipe.sv
// Elastic valid/ready pipeline applying the DES initial (IP) or final (FP) permutation per block,
// with a wrapping delivered-block counter. Define DES_PERM_SELFCHECK_EN to enable the perm_err self-check.
module des_permutation_pipe #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [0:63]      in_block,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:63]      out_block,
    output logic             out_mode,
    output logic [CNT_W-1:0] blk_count,
    output logic             perm_err
);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("des_permutation_pipe: LATENCY must be in 1..4");
    end

    // Source bit (0-based, MSB-first) feeding output bit i, derived from the table row/column pattern.
    function automatic logic [5:0] ip_src(input int i);
        int r;
        int c;
        r = i / 8;
        c = i % 8;
        return 6'(((r < 4) ? (57 + 2 * r) : (56 + 2 * (r - 4))) - 8 * c);
    endfunction

    function automatic logic [5:0] fp_src(input int i);
        int r;
        int c;
        r = i / 8;
        c = i % 8;
        return 6'((((c % 2) == 0) ? 39 : 7) - r + 8 * (c / 2));
    endfunction

    function automatic logic [0:63] perm_ip(input logic [0:63] b);
        logic [0:63] o;
        for (int i = 0; i < 64; i++) o[i] = b[ip_src(i)];
        return o;
    endfunction

    function automatic logic [0:63] perm_fp(input logic [0:63] b);
        logic [0:63] o;
        for (int i = 0; i < 64; i++) o[i] = b[fp_src(i)];
        return o;
    endfunction

    logic [LATENCY-1:0]       vld_q, vld_d;
    logic [LATENCY-1:0]       mode_q, mode_d;
    logic [LATENCY-1:0][0:63] blk_q, blk_d;
    logic [CNT_W-1:0]         blk_count_q, blk_count_d;

    logic [LATENCY-1:0]       rdy;
    logic [LATENCY-1:0]       src_v;
    logic [LATENCY-1:0]       src_m;
    logic [LATENCY-1:0][0:63] src_b;
    logic [0:63]              perm_in;

`ifdef DES_PERM_SELFCHECK_EN
    logic [LATENCY-1:0][0:63] org_q, org_d;
    logic [LATENCY-1:0][0:63] src_o;
    logic                     err_q, err_d;
    logic [0:63]              inv_out;
`endif

    assign perm_in = in_mode ? perm_fp(in_block) : perm_ip(in_block);

    // Stage k can take new content when out_ready is high or any stage from k onward holds a bubble;
    // closed form keeps the ready chain free of self-referencing combinational loops.
    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        assign rdy[k] = out_ready || !(&vld_q[LATENCY-1:k]);
        if (k == 0) begin : g_head
            assign src_v[k] = in_valid;
            assign src_m[k] = in_mode;
            assign src_b[k] = perm_in;
`ifdef DES_PERM_SELFCHECK_EN
            assign src_o[k] = in_block;
`endif
        end else begin : g_body
            assign src_v[k] = vld_q[k-1];
            assign src_m[k] = mode_q[k-1];
            assign src_b[k] = blk_q[k-1];
`ifdef DES_PERM_SELFCHECK_EN
            assign src_o[k] = org_q[k-1];
`endif
        end
    end

    always_comb begin
        vld_d  = vld_q;
        mode_d = mode_q;
        blk_d  = blk_q;
`ifdef DES_PERM_SELFCHECK_EN
        org_d  = org_q;
`endif
        for (int k = 0; k < LATENCY; k++) begin
            if (rdy[k]) begin
                vld_d[k] = src_v[k];
                // Data only moves with a valid source so an idle stage keeps its last value.
                if (src_v[k]) begin
                    mode_d[k] = src_m[k];
                    blk_d[k]  = src_b[k];
`ifdef DES_PERM_SELFCHECK_EN
                    org_d[k]  = src_o[k];
`endif
                end
            end
        end
    end

    always_comb begin
        blk_count_d = blk_count_q;
        if (vld_q[LATENCY-1] && out_ready) blk_count_d = blk_count_q + CNT_W'(1);
    end

`ifdef DES_PERM_SELFCHECK_EN
    // FP undoes IP and vice versa, so the opposite permutation must reproduce the source block.
    assign inv_out = mode_q[LATENCY-1] ? perm_ip(blk_q[LATENCY-1]) : perm_fp(blk_q[LATENCY-1]);

    always_comb begin
        err_d = err_q;
        if (vld_q[LATENCY-1] && (inv_out != org_q[LATENCY-1])) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            org_q <= '0;
            err_q <= 1'b0;
        end else begin
            org_q <= org_d;
            err_q <= err_d;
        end
    end

    assign perm_err = err_q;
`else
    assign perm_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_q       <= '0;
            mode_q      <= '0;
            blk_q       <= '0;
            blk_count_q <= '0;
        end else begin
            vld_q       <= vld_d;
            mode_q      <= mode_d;
            blk_q       <= blk_d;
            blk_count_q <= blk_count_d;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_q[LATENCY-1];
    assign out_mode  = mode_q[LATENCY-1];
    assign out_block = blk_q[LATENCY-1];
    assign blk_count = blk_count_q;

endmodule
